// File: rtl/ssp_pkg.sv
// Shared types and constants for the SSP bus initiator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ssp_pkg;

  localparam int SSP_FRM_BITS  = 16;
  localparam int SSP_DATA_BITS = 12;
  localparam int SSP_RA_BITS   = 3;

  // Bit counter runs from the frame MSB down to 0; data phase is the low 12 bits.
  localparam logic [3:0] SSP_BIT_FIRST = 4'(SSP_FRM_BITS - 1);
  localparam logic [3:0] SSP_DATA_TOP  = 4'(SSP_DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } ssp_state_e;

endpackage

// File: rtl/ssp_sck_gen.sv
// SCK divider: pCLK_DIV cycles low then pCLK_DIV cycles high while enabled.
// Latency: SCK is registered; rise/fall strobes flag the cycle before each edge.
// Backpressure: none; divider and SCK are cleared whenever en is low.
module ssp_sck_gen #(
  parameter int pCLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sck,
  output logic sck_rise,
  output logic sck_fall
);

  localparam int DIV_W = $clog2(pCLK_DIV + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(pCLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             sck_q, sck_d;
  logic             tick;

  // Count half-period cycles and toggle SCK at the end of each half-period.
  always_comb begin
    tick  = en && (div_q == DIV_LAST);
    div_d = '0;
    sck_d = 1'b0;
    if (en) begin
      div_d = tick ? '0 : div_q + DIV_W'(1);
      sck_d = tick ? ~sck_q : sck_q;
    end
  end

  // Divider and SCK state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
      sck_q <= 1'b0;
    end else begin
      div_q <= div_d;
      sck_q <= sck_d;
    end
  end

  assign sck      = sck_q;
  assign sck_rise = tick & ~sck_q;
  assign sck_fall = tick & sck_q;

endmodule

// File: rtl/ssp_uart_host.sv
// SSP bus initiator: frames one register command as a 16-bit SSP cycle and returns SSP_DO.
// Latency: accept to Rsp_Vld = 1 + pSETUP + 32*pCLK_DIV cycles; next accept pGAP+1 cycles later.
// Backpressure: Cmd_Rdy only in IDLE, unaccepted commands are dropped; Rsp_Vld cannot be stalled.
module ssp_uart_host
  import ssp_pkg::*;
#(
  parameter int pCLK_DIV = 2,
  parameter int pSETUP   = 2,
  parameter int pGAP     = 4
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     Cmd_Vld,
  output logic                     Cmd_Rdy,
  input  logic [SSP_RA_BITS-1:0]   Cmd_RA,
  input  logic                     Cmd_WnR,
  input  logic [SSP_DATA_BITS-1:0] Cmd_DI,
  output logic                     Rsp_Vld,
  output logic [SSP_DATA_BITS-1:0] Rsp_DO,
  output logic                     Busy,
  output logic                     SSP_SSEL,
  output logic                     SSP_SCK,
  output logic [SSP_RA_BITS-1:0]   SSP_RA,
  output logic                     SSP_WnR,
  output logic                     SSP_En,
  output logic                     SSP_EOC,
  output logic [SSP_DATA_BITS-1:0] SSP_DI,
  input  logic [SSP_DATA_BITS-1:0] SSP_DO
);

  localparam int CNT_MAX = (pSETUP > pGAP) ? pSETUP : pGAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(pSETUP - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(pGAP - 1);

  ssp_state_e               state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [3:0]               bit_q, bit_d;
  logic [SSP_RA_BITS-1:0]   ra_q, ra_d;
  logic                     wnr_q, wnr_d;
  logic [SSP_DATA_BITS-1:0] di_q, di_d;
  logic [SSP_DATA_BITS-1:0] rsp_do_q, rsp_do_d;
  logic                     rsp_vld_q, rsp_vld_d;
  logic                     ssel_q, ssel_d;
  logic                     en_q, en_d;
  logic                     eoc_q, eoc_d;
  logic                     busy_q, busy_d;
  logic                     rdy_q, rdy_d;

  logic accept;
  logic sck, sck_rise, sck_fall;

  // SCK only runs during SHIFT, so the divider restarts cleanly every frame.
  ssp_sck_gen #(
    .pCLK_DIV (pCLK_DIV)
  ) u_sck_gen (
    .clk      (Clk),
    .rst      (Rst),
    .en       (state_q == SHIFT),
    .sck      (sck),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall)
  );

  // Next-state, counters, command/response capture and registered SSP outputs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    ra_d     = ra_q;
    wnr_d    = wnr_q;
    di_d     = di_q;
    rsp_do_d = rsp_do_q;
    accept   = Cmd_Vld && rdy_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SETUP;
          cnt_d   = SETUP_LOAD;
          bit_d   = SSP_BIT_FIRST;
          ra_d    = Cmd_RA;
          wnr_d   = Cmd_WnR;
          di_d    = Cmd_DI;
        end
      end
      SETUP: begin
        if (cnt_q == '0) state_d = SHIFT;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      SHIFT: begin
        // Slave data is sampled on the SCK rise of the last bit.
        if (sck_rise && (bit_q == 4'd0)) rsp_do_d = SSP_DO;
        if (sck_fall) begin
          if (bit_q == 4'd0) state_d = HOLD;
          else               bit_d   = bit_q - 4'd1;
        end
      end
      HOLD: begin
        state_d = GAP;
        cnt_d   = GAP_LOAD;
      end
      GAP: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they line up with the state register.
    ssel_d    = (state_d == SETUP) || (state_d == SHIFT) || (state_d == HOLD);
    en_d      = (state_d == SHIFT) && (bit_d <= SSP_DATA_TOP);
    eoc_d     = (state_d == SHIFT) && (bit_d == 4'd0);
    rsp_vld_d = (state_d == HOLD);
    busy_d    = (state_d != IDLE);
    rdy_d     = (state_d == IDLE);
  end

  // State and output registers; reset drops any frame in flight.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      ra_q      <= '0;
      wnr_q     <= 1'b0;
      di_q      <= '0;
      rsp_do_q  <= '0;
      rsp_vld_q <= 1'b0;
      ssel_q    <= 1'b0;
      en_q      <= 1'b0;
      eoc_q     <= 1'b0;
      busy_q    <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      ra_q      <= ra_d;
      wnr_q     <= wnr_d;
      di_q      <= di_d;
      rsp_do_q  <= rsp_do_d;
      rsp_vld_q <= rsp_vld_d;
      ssel_q    <= ssel_d;
      en_q      <= en_d;
      eoc_q     <= eoc_d;
      busy_q    <= busy_d;
      rdy_q     <= rdy_d;
    end
  end

  assign Cmd_Rdy  = rdy_q;
  assign Busy     = busy_q;
  assign Rsp_Vld  = rsp_vld_q;
  assign Rsp_DO   = rsp_do_q;
  assign SSP_SSEL = ssel_q;
  assign SSP_SCK  = sck;
  assign SSP_RA   = ra_q;
  assign SSP_WnR  = wnr_q;
  assign SSP_En   = en_q;
  assign SSP_EOC  = eoc_q;
  assign SSP_DI   = di_q;

endmodule
